mem_arbiter: RTL

- Shares one single-port synchronous memory between the core's instruction-fetch port and data port.
- Arbitrates each cycle, accepts at most one access, routes 1-cycle-latency read data back to the owning port, and guarantees instruction-fetch forward progress under sustained data traffic.
- Sits between the core and external memory: the core's two ports connect to the requester side, and the memory model connects to the mem_* side.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous memory between the core's
//            instruction-fetch port (i_*) and data port (d_*). At most one
//            access is accepted per cycle. Read data (1-cycle latency) is
//            steered back to the port that issued the read. A pending fetch
//            is forced through after MAX_WAIT consecutive denied cycles.
//
// Ports    : sysclk, nrst_in              clock / async active-low reset
//            i_req,i_addr -> i_gnt        fetch request / accept
//            i_rvalid,i_rdata             fetch read return
//            d_req,d_we,d_addr,d_wdata    data request
//            d_gnt,d_rvalid,d_rdata       data accept / read return
//            mem_en,mem_we,mem_addr,      memory command
//            mem_wdata, mem_rdata         memory data
//            busy                         a read is outstanding
//
// Options  : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests go to
//            the port that did not own the previous transfer; the MAX_WAIT
//            override still applies. Undefined: fixed data-port priority.
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MEM_AW   = 20,
  parameter int MAX_WAIT = 15
) (
  input  logic              sysclk,
  input  logic              nrst_in,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  // Owner encoding shared by rd_owner and last_owner.
  localparam logic       c_own_data  = 1'b0;
  localparam logic       c_own_fetch = 1'b1;
  localparam logic [7:0] c_max_wait  = 8'(MAX_WAIT);

  logic       r_rd_pend;
  logic       r_rd_owner;
  logic       r_last_owner;
  logic [7:0] r_wait_cnt;

  logic       w_starved;
  logic       w_i_wins;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_rd_accept;

  // --------------------------------------------------------------------------
  // Grant. w_i_wins only matters when both ports request. Grants are gated
  // by nrst_in so nothing is accepted while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_starved = (r_wait_cnt == c_max_wait);
`ifdef ARB_ROUND_ROBIN_EN
    w_i_wins  = w_starved | (r_last_owner == c_own_data);
`else
    w_i_wins  = w_starved;
`endif
    w_i_gnt     = nrst_in & i_req & (~d_req | w_i_wins);
    w_d_gnt     = nrst_in & d_req & ~w_i_gnt;
    w_rd_accept = w_i_gnt | (w_d_gnt & ~d_we);
  end

`ifndef ARB_ROUND_ROBIN_EN
  // last_owner is tracked in both builds but only steers grants with
  // round-robin enabled.
  logic w_unused_last_owner;
  assign w_unused_last_owner = r_last_owner;
`endif

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  // --------------------------------------------------------------------------
  // Memory command. Fetch never writes, so write data always comes from the
  // data port. When idle the address follows the data port (don't-care).
  // --------------------------------------------------------------------------
  assign mem_en    = w_i_gnt | w_d_gnt;
  assign mem_we    = w_d_gnt & d_we;
  assign mem_addr  = w_i_gnt ? i_addr[MEM_AW+1:2] : d_addr[MEM_AW+1:2];
  assign mem_wdata = d_wdata;

  // Byte-offset bits and bits above the memory range are dropped on purpose.
  logic w_unused_addr_low;
  assign w_unused_addr_low = ^{i_addr[1:0], d_addr[1:0]};

  if (ADDR_W > MEM_AW + 2) begin : g_addr_upper
    logic w_unused_addr_high;
    assign w_unused_addr_high = ^{i_addr[ADDR_W-1:MEM_AW+2],
                                  d_addr[ADDR_W-1:MEM_AW+2]};
  end

  // --------------------------------------------------------------------------
  // Read return: the memory answers one cycle after the accepted read, so
  // a single pending flag plus owner bit is enough even for back-to-back
  // reads (each accepted read overwrites the previous, already-returned one).
  // --------------------------------------------------------------------------
  assign i_rvalid = r_rd_pend & (r_rd_owner == c_own_fetch);
  assign d_rvalid = r_rd_pend & (r_rd_owner == c_own_data);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign busy     = r_rd_pend;

  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= c_own_data;
      r_last_owner <= c_own_data;
      r_wait_cnt   <= 8'd0;
    end else begin
      r_rd_pend <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_owner <= w_i_gnt ? c_own_fetch : c_own_data;
      end
      if (w_i_gnt | w_d_gnt) begin
        r_last_owner <= w_i_gnt ? c_own_fetch : c_own_data;
      end
      // Count consecutive denied fetch cycles; saturate at the threshold so
      // the override stays asserted until the fetch is actually taken.
      if (i_req & ~w_i_gnt) begin
        if (r_wait_cnt != c_max_wait) begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

endmodule
`default_nettype wire
